pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the PC and all address port widths.
REQ-002 Parameter RESET_VEC, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_4180, SHALL be the exception handler entry address.
REQ-004 Parameter STEP, default 4, SHALL be the sequential increment.
REQ-005 The ports SHALL be, in order:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- stall  input  1  pipeline hold request.
- br_taken  input  1  branch redirect request.
- br_target  input  WIDTH  branch destination.
- jump  input  1  jump redirect request.
- jump_target  input  WIDTH  jump destination.
- exc  input  1  exception request.
- eret  input  1  exception return request.
- fetch_ready  input  1  instruction memory accepts the current fetch.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus  output  WIDTH  pc + STEP (combinational).
- fetch_valid  output  1  pc is a valid fetch request.
- epc  output  WIDTH  saved exception PC (registered).
- misalign  output  1  pc[1:0] != 0 while fetch_valid.

Function
REQ-006 The FSM SHALL have three states: BOOT, RUN and HOLD.
REQ-007 BOOT SHALL last exactly one cycle after reset release with fetch_valid=0, then enter RUN with pc unchanged.
REQ-008 In RUN and HOLD, fetch_valid SHALL be 1.
REQ-009 Each cycle, next-PC selection SHALL use this priority, highest first:
- exc -> EXC_VEC, and epc <= pc.
- eret -> epc.
- br_taken -> br_target.
- jump -> jump_target.
- stall -> hold pc.
- fetch_ready=0 -> hold pc.
- otherwise -> pc_plus.
REQ-010 Any redirect (exc, eret, br_taken, jump) SHALL load pc on the next edge regardless of stall or fetch_ready, and SHALL leave state RUN.
REQ-011 With no redirect, stall=1 or fetch_ready=0 SHALL move the FSM to HOLD; otherwise the FSM SHALL be in RUN.
REQ-012 HOLD SHALL keep pc constant and SHALL return to RUN in the cycle after stall=0 and fetch_ready=1.
REQ-013 epc SHALL change only on an accepted exc.
REQ-014 exc and eret asserted together SHALL resolve as exc; epc SHALL take the current pc, not the eret target.
REQ-015 pc_plus SHALL wrap modulo 2^WIDTH; pc=all-ones-minus-3 SHALL give pc_plus=0 with no flag.
REQ-016 misalign SHALL be combinational from pc.
REQ-017 misalign SHALL NOT alter pc selection; the exception source reports it upstream.
REQ-018 Redirects in BOOT SHALL be ignored.

Reset
REQ-019 While rst=1: pc=RESET_VEC, epc=RESET_VEC, state=BOOT, fetch_valid=0, misalign=0.
REQ-020 rst asserted mid-operation (including during HOLD or the same cycle as exc) SHALL take effect immediately without waiting for clk, with no epc capture.
REQ-021 After rst deasserts, the first rising edge SHALL move the FSM BOOT->RUN, and the second rising edge SHALL be the first that can advance pc.

Verification
REQ-022 Reset then free-run with fetch_ready=1 -> fetch_valid rises 1 cycle after release; pc sequence 0x3000, 0x3004, 0x3008.
REQ-023 At pc=0x3008, stall=1 for 3 cycles -> pc held at 0x3008 for 3 cycles in HOLD; pc=0x300C one cycle after stall drops.
REQ-024 At pc=0x3010, stall=1 together with br_taken=1 and br_target=0x3400 -> pc=0x3400 on the next edge.
REQ-025 At pc=0x3020, exc=1 with eret=1 and br_taken=1 -> pc=0x4180, epc=0x3020; a later eret alone -> pc=0x3020.
REQ-026 jump_target=0x3002 -> misalign=1 while pc=0x3002; sequence continues at 0x3006.
REQ-027 WIDTH=16, RESET_VEC=16'hFFFC -> pc 0xFFFC then 0x0000; rst pulsed asynchronously mid-cycle -> pc=0xFFFC before the next edge.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program counter controller: boot/run/hold sequencing with prioritised redirects
// (exception, exception return, branch, jump) and a saved exception PC.
module pc_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int               STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  input  logic             eret,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] epc,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_next, epc_next;
  logic             redirect;

  assign pc_plus     = pc + STEP_W;
  assign fetch_valid = (state != BOOT);
  assign misalign    = fetch_valid && (pc[1:0] != 2'b00);
  assign redirect    = exc | eret | br_taken | jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_VEC;
      epc   <= RESET_VEC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
    end
  end

  // BOOT ignores every request; misalign is reported only and never steers selection.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
    case (state)
      BOOT: state_next = RUN;
      RUN, HOLD: begin
        if (exc) begin
          pc_next  = EXC_VEC;
          epc_next = pc;
        end else if (eret) begin
          pc_next = epc;
        end else if (br_taken) begin
          pc_next = br_target;
        end else if (jump) begin
          pc_next = jump_target;
        end else if (!stall && fetch_ready) begin
          pc_next = pc_plus;
        end
        if (redirect || (!stall && fetch_ready)) state_next = RUN;
        else                                     state_next = HOLD;
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: expected PCs are queued as stimulus is driven
// and compared after each rising edge; a 16-bit instance covers wraparound.
module tb_pc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        stall, br_taken, jump, exc, eret, fetch_ready;
  logic [31:0] br_target, jump_target;
  logic [31:0] pc, pc_plus, epc;
  logic        fetch_valid, misalign;
  logic [15:0] pc16, pc_plus16, epc16;
  logic        fetch_valid16, misalign16;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target), .exc(exc), .eret(eret),
    .fetch_ready(fetch_ready), .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .epc(epc), .misalign(misalign)
  );

  pc_ctrl #(.WIDTH(16), .RESET_VEC(16'hFFFC), .EXC_VEC(16'h4180), .STEP(4)) dut16 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target[15:0]),
    .jump(jump), .jump_target(jump_target[15:0]), .exc(exc), .eret(eret),
    .fetch_ready(fetch_ready), .pc(pc16), .pc_plus(pc_plus16), .fetch_valid(fetch_valid16),
    .epc(epc16), .misalign(misalign16)
  );

  task automatic idle();
    stall = 0; br_taken = 0; jump = 0; exc = 0; eret = 0; fetch_ready = 1;
    br_target = '0; jump_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    #2;
    n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h3000); end
    n_tests++; if (epc !== 32'h3000) begin n_fail++; $display("[TB] FAIL reset_epc: got %h want %h", epc, 32'h3000); end
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
    n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_misalign: got %b want 0", misalign); end
  endtask

  task automatic test_free_run();
    tick();
    rst = 1'b0;
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_fetch_valid: got %b want 0", fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h3000 + 32'(4 * i));
      tick();
      exp_pc = sb.pop_front();
      n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL free_run_pc: got %h want %h", pc, exp_pc); end
      n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL free_run_fetch_valid: got %b want 1", fetch_valid); end
    end
    n_tests++; if (pc_plus !== 32'h300C) begin n_fail++; $display("[TB] FAIL pc_plus: got %h want %h", pc_plus, 32'h300C); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h3008);
      tick();
      exp_pc = sb.pop_front();
      n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL stall_hold_pc: got %h want %h", pc, exp_pc); end
      n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_fetch_valid: got %b want 1", fetch_valid); end
    end
    stall = 0;
    sb.push_back(32'h300C);
    sb.push_back(32'h3010);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_pc = sb.pop_front();
      n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL stall_release_pc: got %h want %h", pc, exp_pc); end
    end
  endtask

  task automatic test_branch_over_stall();
    stall = 1; br_taken = 1; br_target = 32'h3400;
    sb.push_back(32'h3400);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL branch_over_stall: got %h want %h", pc, exp_pc); end
    idle();
    jump = 1; jump_target = 32'h3020;
    sb.push_back(32'h3020);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL jump_pc: got %h want %h", pc, exp_pc); end
    idle();
  endtask

  task automatic test_exc_eret();
    exc = 1; eret = 1; br_taken = 1; br_target = 32'h3400;
    sb.push_back(32'h4180);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL exc_priority_pc: got %h want %h", pc, exp_pc); end
    n_tests++; if (epc !== 32'h3020) begin n_fail++; $display("[TB] FAIL exc_epc: got %h want %h", epc, 32'h3020); end
    idle();
    sb.push_back(32'h4184);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL handler_pc: got %h want %h", pc, exp_pc); end
    n_tests++; if (epc !== 32'h3020) begin n_fail++; $display("[TB] FAIL epc_stable: got %h want %h", epc, 32'h3020); end
    eret = 1;
    sb.push_back(32'h3020);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL eret_pc: got %h want %h", pc, exp_pc); end
    idle();
  endtask

  task automatic test_fetch_ready();
    fetch_ready = 0;
    sb.push_back(32'h3020);
    sb.push_back(32'h3020);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_pc = sb.pop_front();
      n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL not_ready_hold: got %h want %h", pc, exp_pc); end
    end
    fetch_ready = 1;
    sb.push_back(32'h3024);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL ready_advance: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_misalign();
    jump = 1; jump_target = 32'h3002;
    sb.push_back(32'h3002);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL misalign_jump_pc: got %h want %h", pc, exp_pc); end
    n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_flag: got %b want 1", misalign); end
    idle();
    sb.push_back(32'h3006);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL misalign_continue: got %h want %h", pc, exp_pc); end
    n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_flag2: got %b want 1", misalign); end
    jump = 1; jump_target = 32'h3008;
    sb.push_back(32'h3008);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL realign_pc: got %h want %h", pc, exp_pc); end
    n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL realign_flag: got %b want 0", misalign); end
    idle();
  endtask

  task automatic test_async_reset_exc();
    exc = 1;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("[TB] FAIL async_rst_pc: got %h want %h", pc, 32'h3000); end
    n_tests++; if (epc !== 32'h3000) begin n_fail++; $display("[TB] FAIL async_rst_epc: got %h want %h", epc, 32'h3000); end
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_rst_fetch_valid: got %b want 0", fetch_valid); end
  endtask

  task automatic test_boot_redirect();
    exc = 1; jump = 1; jump_target = 32'h5000;
    tick();
    rst = 1'b0;
    sb.push_back(32'h3000);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL boot_ignores_redirect: got %h want %h", pc, exp_pc); end
    n_tests++; if (epc !== 32'h3000) begin n_fail++; $display("[TB] FAIL boot_epc: got %h want %h", epc, 32'h3000); end
    idle();
    sb.push_back(32'h3004);
    tick();
    exp_pc = sb.pop_front();
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL after_boot_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_wrap16();
    idle();
    rst = 1'b1;
    tick();
    n_tests++; if (pc16 !== 16'hFFFC) begin n_fail++; $display("[TB] FAIL w16_reset_pc: got %h want %h", pc16, 16'hFFFC); end
    n_tests++; if (pc_plus16 !== 16'h0000) begin n_fail++; $display("[TB] FAIL w16_pc_plus_wrap: got %h want %h", pc_plus16, 16'h0000); end
    rst = 1'b0;
    tick();
    n_tests++; if (pc16 !== 16'hFFFC) begin n_fail++; $display("[TB] FAIL w16_boot_pc: got %h want %h", pc16, 16'hFFFC); end
    tick();
    n_tests++; if (pc16 !== 16'h0000) begin n_fail++; $display("[TB] FAIL w16_wrap_pc: got %h want %h", pc16, 16'h0000); end
    n_tests++; if (misalign16 !== 1'b0) begin n_fail++; $display("[TB] FAIL w16_misalign: got %b want 0", misalign16); end
    n_tests++; if (fetch_valid16 !== 1'b1) begin n_fail++; $display("[TB] FAIL w16_fetch_valid: got %b want 1", fetch_valid16); end
    tick();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (pc16 !== 16'hFFFC) begin n_fail++; $display("[TB] FAIL w16_async_rst_pc: got %h want %h", pc16, 16'hFFFC); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch_over_stall();
    test_exc_eret();
    test_fetch_ready();
    test_misalign();
    test_async_reset_exc();
    test_boot_redirect();
    test_wrap16();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
